// File: rtl/stack_pkg.sv
// Shared types for the parameterised LIFO stack: decoded operations and
// the occupancy state of the stack.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_PASS
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_e;

endpackage

// File: rtl/param_stack_if.sv
// Request/response bundle of the stack; the master drives requests, the
// stack (slave) returns data, occupancy and sticky error flags.
interface param_stack_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [DATA_W-1:0] top;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, data_in, err_clr,
        input  data_out, data_valid, top, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in, err_clr,
        output data_out, data_valid, top, count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module stack_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    // Kept as discrete flops so the async read is never mapped onto block RAM.
    (* keep *) logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_stack.sv
// LIFO stack top: request decode, occupancy FSM, count, output register
// and sticky overflow/underflow flags around the stack_regfile storage.
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic clk,
    input  logic reset_n,
    param_stack_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    op_e               op;
    state_e            state_q, state_n;
    logic [CW-1:0]     count_q, count_n;
    logic [DATA_W-1:0] data_out_q, rd_data;
    logic              data_valid_q, overflow_q, underflow_q;
    logic              we;
    logic [AW-1:0]     wr_addr, rd_addr;

    always_comb begin
        op = OP_NOP;
        if (bus.push && bus.pop) begin
            op = (state_q == ST_EMPTY) ? OP_PASS : OP_REPLACE;
        end else if (bus.push) begin
            op = OP_PUSH;
        end else if (bus.pop) begin
            op = OP_POP;
        end
    end

    // Replace writes over the current top; a plain push writes one above it.
    always_comb begin
        count_n = count_q;
        we      = 1'b0;
        rd_addr = AW'(count_q - CW'(1));
        wr_addr = count_q[AW-1:0];
        case (op)
            OP_PUSH: begin
                if (state_q != ST_FULL) begin
                    we      = 1'b1;
                    count_n = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (state_q != ST_EMPTY) begin
                    count_n = count_q - CW'(1);
                end
            end
            OP_REPLACE: begin
                we      = 1'b1;
                wr_addr = rd_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_EMPTY:   if (count_n != '0) state_n = ST_PARTIAL;
            ST_PARTIAL: begin
                if (count_n == CW'(DEPTH)) state_n = ST_FULL;
                else if (count_n == '0)    state_n = ST_EMPTY;
            end
            ST_FULL:    if (count_n != CW'(DEPTH)) state_n = ST_PARTIAL;
            default:    state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
        end
    end

    // A fresh error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (op)
                OP_POP: begin
                    if (state_q != ST_EMPTY) begin
                        data_out_q   <= rd_data;
                        data_valid_q <= 1'b1;
                    end
                end
                OP_REPLACE: begin
                    data_out_q   <= rd_data;
                    data_valid_q <= 1'b1;
                end
                OP_PASS: begin
                    data_out_q   <= bus.data_in;
                    data_valid_q <= 1'b1;
                end
                default: ;
            endcase
            overflow_q  <= (op == OP_PUSH && state_q == ST_FULL) || (overflow_q && !bus.err_clr);
            underflow_q <= (op == OP_POP && state_q == ST_EMPTY) || (underflow_q && !bus.err_clr);
        end
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (bus.data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.top        = (state_q == ST_EMPTY) ? '0 : rd_data;
    assign bus.count      = count_q;
    assign bus.full       = (state_q == ST_FULL);
    assign bus.empty      = (state_q == ST_EMPTY);
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack at DATA_W=8, DEPTH=4 with
// hand-computed expectations.
module tb_param_stack;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    param_stack_if #(.DATA_W(8), .DEPTH(4)) bus ();

    param_stack #(.DATA_W(8), .DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one request across a rising edge; returns at the next falling edge.
    task automatic applyStimulus(input logic p_push, input logic p_pop, input logic [7:0] data, input logic clr);
        bus.push    = p_push;
        bus.pop     = p_pop;
        bus.data_in = data;
        bus.err_clr = clr;
        @(posedge clk);
        @(negedge clk);
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] pushes [4];
        logic [7:0] pops   [4];
        pushes = '{8'h11, 8'h22, 8'h33, 8'h44};
        pops   = '{8'h44, 8'h33, 8'h22, 8'h11};
        checks = 0;
        errors = 0;
        reset_n     = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = 8'h00;
        bus.err_clr = 1'b0;

        #1;
        checkOutput("reset_count", 32'(bus.count), 0);
        checkOutput("reset_empty", 32'(bus.empty), 1);
        checkOutput("reset_full", 32'(bus.full), 0);
        checkOutput("reset_data_out", 32'(bus.data_out), 0);
        checkOutput("reset_valid", 32'(bus.data_valid), 0);
        checkOutput("reset_top", 32'(bus.top), 0);
        checkOutput("reset_ovf", 32'(bus.overflow), 0);
        checkOutput("reset_udf", 32'(bus.underflow), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, pushes[i], 1'b0);
            checkOutput("push_count", 32'(bus.count), 32'(i + 1));
            checkOutput("push_top", 32'(bus.top), 32'(pushes[i]));
        end
        checkOutput("fill_full", 32'(bus.full), 1);
        checkOutput("fill_ovf", 32'(bus.overflow), 0);

        applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
        checkOutput("ovf_flag", 32'(bus.overflow), 1);
        checkOutput("ovf_count", 32'(bus.count), 4);
        checkOutput("ovf_top", 32'(bus.top), 'h44);
        checkOutput("ovf_full", 32'(bus.full), 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            checkOutput("pop_data", 32'(bus.data_out), 32'(pops[i]));
            checkOutput("pop_valid", 32'(bus.data_valid), 1);
            checkOutput("pop_count", 32'(bus.count), 32'(3 - i));
        end
        checkOutput("drain_empty", 32'(bus.empty), 1);
        checkOutput("drain_top", 32'(bus.top), 0);
        checkOutput("drain_udf", 32'(bus.underflow), 0);

        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("udf_flag", 32'(bus.underflow), 1);
        checkOutput("udf_valid", 32'(bus.data_valid), 0);
        checkOutput("udf_held", 32'(bus.data_out), 'h11);
        checkOutput("udf_ovf_sticky", 32'(bus.overflow), 1);

        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        checkOutput("clr_udf_wins", 32'(bus.underflow), 1);
        checkOutput("clr_ovf", 32'(bus.overflow), 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("clr_udf", 32'(bus.underflow), 0);

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("idle_valid", 32'(bus.data_valid), 0);
        checkOutput("idle_held", 32'(bus.data_out), 'h11);

        applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
        checkOutput("pass_data", 32'(bus.data_out), 'h5A);
        checkOutput("pass_valid", 32'(bus.data_valid), 1);
        checkOutput("pass_count", 32'(bus.count), 0);
        checkOutput("pass_ovf", 32'(bus.overflow), 0);
        checkOutput("pass_udf", 32'(bus.underflow), 0);

        applyStimulus(1'b1, 1'b0, 8'hA0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hB0, 1'b0);
        checkOutput("repl_data", 32'(bus.data_out), 'hA0);
        checkOutput("repl_valid", 32'(bus.data_valid), 1);
        checkOutput("repl_count", 32'(bus.count), 1);
        checkOutput("repl_top", 32'(bus.top), 'hB0);

        applyStimulus(1'b1, 1'b0, 8'h01, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h02, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h03, 1'b0);
        checkOutput("refill_full", 32'(bus.full), 1);
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
        checkOutput("repl_full_data", 32'(bus.data_out), 'h03);
        checkOutput("repl_full_count", 32'(bus.count), 4);
        checkOutput("repl_full_ovf", 32'(bus.overflow), 0);
        checkOutput("repl_full_top", 32'(bus.top), 'h77);

        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("pre_rst_count", 32'(bus.count), 3);
        checkOutput("pre_rst_data", 32'(bus.data_out), 'h77);

        // Asynchronous reset pulse fully between two rising edges.
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_count", 32'(bus.count), 0);
        checkOutput("async_empty", 32'(bus.empty), 1);
        checkOutput("async_data_out", 32'(bus.data_out), 0);
        checkOutput("async_top", 32'(bus.top), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'hC3, 1'b0);
        checkOutput("post_rst_count", 32'(bus.count), 1);
        checkOutput("post_rst_top", 32'(bus.top), 'hC3);

        // A request held across an edge while reset is low must be dropped.
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h99, 1'b0);
        checkOutput("rst_drop_count", 32'(bus.count), 0);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h99, 1'b0);
        checkOutput("rst_first_count", 32'(bus.count), 1);
        checkOutput("rst_first_top", 32'(bus.top), 'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; SHALL be ≥1.
REQ-002 Parameter DEPTH, default 16, entry count; SHALL be a power of two ≥2.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous, active-low reset.
REQ-005 Port push, input, 1, push request this cycle.
REQ-006 Port pop, input, 1, pop request this cycle.
REQ-007 Port data_in, input, DATA_W, push/replace data.
REQ-008 Port err_clr, input, 1, clears sticky error flags.
REQ-009 Port data_out, output, DATA_W, last popped word; SHALL hold between pops.
REQ-010 Port data_valid, output, 1, one-cycle pulse marking a new data_out.
REQ-011 Port top, output, DATA_W, combinational peek of the top entry; SHALL be 0 when empty.
REQ-012 Port count, output, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
REQ-013 Port full / empty, output, 1 each, registered occupancy flags.
REQ-014 Port overflow / underflow, output, 1 each, sticky error flags.

Function
REQ-015 Requests SHALL be sampled combinationally with no input registering; a result SHALL appear on the edge that accepts the request (latency 1).
REQ-016 Occupancy state SHALL be one of EMPTY, PARTIAL, FULL.
- EMPTY→PARTIAL on a push.
- PARTIAL→FULL when count reaches DEPTH.
- PARTIAL→EMPTY when count reaches 0.
- FULL→PARTIAL on a pop.
- State SHALL always agree with count; full and empty SHALL be decoded from it.
REQ-017 Push only, not full: mem[count] ← data_in; count+1.
REQ-018 Pop only, not empty: data_out ← mem[count-1]; data_valid=1; count-1.
REQ-019 Push+pop, not empty (including full): replace.
- data_out ← old top; data_valid=1.
- mem[count-1] ← data_in; count unchanged.
- No error is raised.
REQ-020 Push+pop when empty: pass-through.
- data_out ← data_in; data_valid=1.
- count stays 0; no error is raised.
REQ-021 Push only when full: no write; count unchanged; overflow ← 1.
REQ-022 Pop only when empty: data_out held; data_valid=0; underflow ← 1.
REQ-023 Error flags, once set, SHALL hold until err_clr=1.
- err_clr SHALL clear them on the next edge.
- A new error in the same cycle as err_clr SHALL win: the flag stays 1.
REQ-024 Neither push nor pop: all state SHALL hold; data_valid=0.
REQ-025 count arithmetic SHALL use the full $clog2(DEPTH)+1 width, so count=DEPTH never wraps to 0.

Reset
REQ-026 reset_n=0 SHALL immediately (asynchronously) force:
- count=0 and state EMPTY.
- data_out=0, data_valid=0.
- overflow=0, underflow=0.
REQ-027 Storage contents SHALL NOT be reset; top SHALL still read 0 because the stack is empty.
REQ-028 Reset asserted mid-operation SHALL discard any request in that cycle; the first request is accepted on the first rising edge after deassertion.

Structure
REQ-029 A package stack_pkg SHALL hold:
- the operation enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_PASS};
- the occupancy state enum {ST_EMPTY, ST_PARTIAL, ST_FULL}.
REQ-030 Storage SHALL be one sub-module, stack_regfile.
- Parameters DATA_W and DEPTH.
- One write port; one asynchronous read port.
- Marked keep so it is not inferred as block RAM.
REQ-031 The top level SHALL contain decode, the occupancy state machine, the count and the flags.

Verification (DATA_W=8, DEPTH=4)
REQ-032 Push 0x11, 0x22, 0x33, 0x44, then a 5th push 0x55 → full=1, count=4, overflow=1, top=0x44.
REQ-033 From that state, pop ×4 → data_out 0x44, 0x33, 0x22, 0x11, each with a data_valid pulse; then empty=1, and a 5th pop gives underflow=1 with data_out held at 0x11.
REQ-034 Push 0xA0, then push+pop with 0xB0 → data_out=0xA0, data_valid=1, count=1, top=0xB0.
REQ-035 Push+pop 0x5A when empty → data_out=0x5A, count=0, no error flags; then push+pop 0x77 when full → no overflow, count stays 4.
REQ-036 Set underflow, then assert err_clr in the same cycle as a pop on empty → underflow stays 1; err_clr alone on the next cycle → underflow=0.
REQ-037 Push 3 words, then pulse reset_n low between clock edges → count=0, empty=1 and data_out=0 before the next edge; a push afterwards → count=1.
